rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
- Small in-order commit queue (reorder buffer) acting as the write-side producer for the architectural register file.
- Issue allocates entries in program order.
- Execution units return results out of order, tagged by entry.
- Retires the oldest ready entry each cycle and drives the register file write port (is_writing_rd / rd_reg_id / rd_val) as a registered one-cycle pulse.
- Handles pipeline flush and rdy_in stall.

Parameters:
- ROB_SIZE_WIDTH, 3, log2 of entry count (8 entries by default).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  ready; all state frozen when low
- flush_pipline  input  1  discard all in-flight entries
- alloc_valid  input  1  issue requests an entry this cycle
- alloc_has_rd  input  1  instruction writes a destination register
- alloc_rd_id  input  5  destination register index
- alloc_tag  output  ROB_SIZE_WIDTH  tag granted on accepted alloc (equals tail pointer; combinational)
- rob_full  output  1  no free entry (combinational from count)
- rob_empty  output  1  no valid entry (combinational from count)
- wb_valid  input  1  result return strobe
- wb_tag  input  ROB_SIZE_WIDTH  entry receiving result
- wb_val  input  32  result value
- is_writing_rd  output  1  register file write enable (registered)
- rd_reg_id  output  5  register file write index (registered)
- rd_val  output  32  register file write data (registered)
- commit_valid  output  1  an entry retired last cycle (registered)
- commit_tag  output  ROB_SIZE_WIDTH  tag retired (registered)

Behaviour:
- Reset is asynchronous (rst_in high).
  - head = tail = 0, count = 0, all entry valid/ready bits 0.
  - is_writing_rd, rd_reg_id, rd_val, commit_valid, commit_tag = 0.
  - Reset mid-operation discards everything immediately.
- rdy_in low: no state or output register changes; alloc/wb inputs ignored; registered outputs hold.
  - The register file also ignores writes while rdy_in is low, so a pending pulse lands exactly once when rdy_in returns.
- Priority per cycle (rdy_in high): flush > {alloc, wb, commit}. The latter three evaluate in parallel.
- Flush:
  - All valid/ready bits cleared; head = tail = count = 0.
  - is_writing_rd and commit_valid = 0 next cycle.
  - Same-cycle alloc, wb and commit are all dropped.
- Alloc:
  - Accepted when alloc_valid && !rob_full. rob_full uses count before this cycle's commit, so no alloc when full even if commit occurs the same cycle.
  - Entry[tail] gets valid = 1, ready = 0, has_rd, rd_id. Tail increments modulo 2^ROB_SIZE_WIDTH.
  - alloc_valid while full is ignored; issue must hold the request.
- Writeback:
  - When wb_valid && entry[wb_tag].valid: entry val = wb_val, ready = 1.
  - wb to an invalid entry is ignored.
  - A repeat wb to a ready entry overwrites val.
  - wb to the slot being allocated in the same cycle is ignored.
- Commit:
  - When entry[head].valid && entry[head].ready, using registered ready from before this cycle's wb:
    - is_writing_rd <= has_rd, rd_reg_id <= rd_id, rd_val <= val;
    - commit_valid <= 1, commit_tag <= head;
    - entry[head].valid <= 0; head increments with wrap.
  - Otherwise is_writing_rd <= 0 and commit_valid <= 0.
  - At most one commit per cycle.
  - wb to the head entry commits the following cycle, giving a minimum result-to-RF-write latency of 2 cycles from wb_valid.
- Count: +1 on alloc, -1 on commit, unchanged when both occur.
  - rob_full = (count == 2^ROB_SIZE_WIDTH); rob_empty = (count == 0).
  - Count width is ROB_SIZE_WIDTH+1.
- rd_id 0 with has_rd = 1 still pulses is_writing_rd; the register file discards writes to x0.
- Pointers wrap naturally; ordering across the wrap is preserved.

Test Plan:
- Reset, then alloc x5 (tag 0); wb tag 0 = 0x1234 → two cycles after wb: is_writing_rd = 1, rd_reg_id = 5, rd_val = 0x1234 for exactly one cycle; rob_empty = 1 afterwards.
- Alloc x1, x2, x3 (tags 0, 1, 2); wb tags 2, 1, 0 with values 0xC, 0xB, 0xA → commits in order x1 = 0xA, x2 = 0xB, x3 = 0xC on consecutive cycles.
- Fill 8 entries → rob_full = 1, 9th alloc not granted, tail unchanged. Commit head while alloc_valid held → alloc refused that cycle, granted next cycle with tag 0 (wrap).
- 4 entries valid, two ready, flush asserted together with wb and alloc → next cycle count = 0, rob_empty = 1, no is_writing_rd pulse. Subsequent alloc gets tag 0.
- Head ready, rdy_in low for 3 cycles → no commit and outputs hold. rdy_in high → a single pulse with correct rd_reg_id/rd_val.
- Alloc with alloc_has_rd = 0 (store/branch), then wb → commit_valid = 1, is_writing_rd = 0. Also assert rst_in asynchronously mid-burst → all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: small in-order reorder buffer that retires completed
// entries oldest-first. It is the write-side producer for the architectural
// register file. Results return out of order, tagged by entry. At most one
// entry retires per cycle, as a registered one-cycle write pulse.
module rob_commit_unit #(
    parameter int ROB_SIZE_WIDTH = 3
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_pipline,
    input  logic                      alloc_valid,
    input  logic                      alloc_has_rd,
    input  logic [4:0]                alloc_rd_id,
    output logic [ROB_SIZE_WIDTH-1:0] alloc_tag,
    output logic                      rob_full,
    output logic                      rob_empty,
    input  logic                      wb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] wb_tag,
    input  logic [31:0]               wb_val,
    output logic                      is_writing_rd,
    output logic [4:0]                rd_reg_id,
    output logic [31:0]               rd_val,
    output logic                      commit_valid,
    output logic [ROB_SIZE_WIDTH-1:0] commit_tag
);

    localparam int                    N        = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0]   FULL_CNT = (ROB_SIZE_WIDTH+1)'(N);
    localparam logic [ROB_SIZE_WIDTH:0]   CNT_ONE  = (ROB_SIZE_WIDTH+1)'(1);
    localparam logic [ROB_SIZE_WIDTH-1:0] PTR_ONE  = ROB_SIZE_WIDTH'(1);

    // Control state
    logic [ROB_SIZE_WIDTH-1:0] head_q, head_d;
    logic [ROB_SIZE_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_SIZE_WIDTH:0]   count_q, count_d;
    logic [N-1:0]              valid_q, valid_d;
    logic [N-1:0]              ready_q, ready_d;

    // Per-entry payload (never needs reset: only read when the entry is valid)
    logic [N-1:0]              has_rd_q, has_rd_d;
    logic [4:0]                rd_id_q [N];
    logic [4:0]                rd_id_d [N];
    logic [31:0]               val_q   [N];
    logic [31:0]               val_d   [N];

    // Registered register-file write port and commit report
    logic                      is_writing_q, is_writing_d;
    logic [4:0]                rd_reg_id_q, rd_reg_id_d;
    logic [31:0]               rd_val_q, rd_val_d;
    logic                      commit_valid_q, commit_valid_d;
    logic [ROB_SIZE_WIDTH-1:0] commit_tag_q, commit_tag_d;

    logic alloc_fire;
    logic wb_fire;
    logic commit_fire;

    assign rob_full  = (count_q == FULL_CNT);
    assign rob_empty = (count_q == '0);
    assign alloc_tag = tail_q;

    // Full is judged on the count before this cycle's commit, so a slot freed
    // by a same-cycle commit is not reusable until the next cycle.
    assign alloc_fire  = alloc_valid && !rob_full;
    // A result aimed at the slot being allocated belongs to a stale entry.
    assign wb_fire     = wb_valid && valid_q[wb_tag] && !(alloc_fire && (wb_tag == tail_q));
    // Commit looks only at registered ready, so a wb to the head retires next cycle.
    assign commit_fire = valid_q[head_q] && ready_q[head_q];

    assign is_writing_rd = is_writing_q;
    assign rd_reg_id     = rd_reg_id_q;
    assign rd_val        = rd_val_q;
    assign commit_valid  = commit_valid_q;
    assign commit_tag    = commit_tag_q;

    // Next-state: freeze when not ready, flush wins, else alloc/wb/commit in parallel
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        valid_d        = valid_q;
        ready_d        = ready_q;
        has_rd_d       = has_rd_q;
        rd_id_d        = rd_id_q;
        val_d          = val_q;
        is_writing_d   = is_writing_q;
        rd_reg_id_d    = rd_reg_id_q;
        rd_val_d       = rd_val_q;
        commit_valid_d = commit_valid_q;
        commit_tag_d   = commit_tag_q;

        if (rdy_in) begin
            if (flush_pipline) begin
                valid_d        = '0;
                ready_d        = '0;
                head_d         = '0;
                tail_d         = '0;
                count_d        = '0;
                is_writing_d   = 1'b0;
                commit_valid_d = 1'b0;
            end else begin
                if (alloc_fire) begin
                    valid_d[tail_q]  = 1'b1;
                    ready_d[tail_q]  = 1'b0;
                    has_rd_d[tail_q] = alloc_has_rd;
                    rd_id_d[tail_q]  = alloc_rd_id;
                    tail_d           = tail_q + PTR_ONE;
                end

                if (wb_fire) begin
                    ready_d[wb_tag] = 1'b1;
                    val_d[wb_tag]   = wb_val;
                end

                if (commit_fire) begin
                    is_writing_d    = has_rd_q[head_q];
                    rd_reg_id_d     = rd_id_q[head_q];
                    rd_val_d        = val_q[head_q];
                    commit_valid_d  = 1'b1;
                    commit_tag_d    = head_q;
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + PTR_ONE;
                end else begin
                    is_writing_d   = 1'b0;
                    commit_valid_d = 1'b0;
                end

                case ({alloc_fire, commit_fire})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // Control and output registers, cleared by asynchronous reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            ready_q        <= '0;
            is_writing_q   <= 1'b0;
            rd_reg_id_q    <= '0;
            rd_val_q       <= '0;
            commit_valid_q <= 1'b0;
            commit_tag_q   <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            valid_q        <= valid_d;
            ready_q        <= ready_d;
            is_writing_q   <= is_writing_d;
            rd_reg_id_q    <= rd_reg_id_d;
            rd_val_q       <= rd_val_d;
            commit_valid_q <= commit_valid_d;
            commit_tag_q   <= commit_tag_d;
        end
    end

    // Entry payload storage
    always_ff @(posedge clk_in) begin
        has_rd_q <= has_rd_d;
        rd_id_q  <= rd_id_d;
        val_q    <= val_d;
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Testbench for rob_commit_unit: table-driven cycle vectors plus hand-written
// sequences, with a scoreboard of expected retirements in program order.
module tb_rob_commit_unit;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic        alloc_valid;
    logic        alloc_has_rd;
    logic [4:0]  alloc_rd_id;
    logic [2:0]  alloc_tag;
    logic        rob_full;
    logic        rob_empty;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [31:0] wb_val;
    logic        is_writing_rd;
    logic [4:0]  rd_reg_id;
    logic [31:0] rd_val;
    logic        commit_valid;
    logic [2:0]  commit_tag;

    rob_commit_unit #(.ROB_SIZE_WIDTH(3)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_pipline (flush_pipline),
        .alloc_valid   (alloc_valid),
        .alloc_has_rd  (alloc_has_rd),
        .alloc_rd_id   (alloc_rd_id),
        .alloc_tag     (alloc_tag),
        .rob_full      (rob_full),
        .rob_empty     (rob_empty),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .wb_val        (wb_val),
        .is_writing_rd (is_writing_rd),
        .rd_reg_id     (rd_reg_id),
        .rd_val        (rd_val),
        .commit_valid  (commit_valid),
        .commit_tag    (commit_tag)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  tag;
        logic        has;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        av;
        logic        has;
        logic [4:0]  rd;
        logic        wv;
        logic [2:0]  wt;
        logic [31:0] wval;
        logic [31:0] sbval;
        logic        chk;
        logic [2:0]  etag;
        logic        efull;
        logic        eempty;
        logic        ecv;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic has, input logic [4:0] rd,
                                input logic wv, input logic [2:0] wt, input logic [31:0] wval,
                                input logic [31:0] sbval, input logic c, input logic [2:0] etag,
                                input logic efull, input logic eempty, input logic ecv);
        vec_t v;
        v.av = av; v.has = has; v.rd = rd; v.wv = wv; v.wt = wt; v.wval = wval;
        v.sbval = sbval; v.chk = c; v.etag = etag; v.efull = efull;
        v.eempty = eempty; v.ecv = ecv;
        return v;
    endfunction

    function automatic exp_t mke(input logic [2:0] tag, input logic has,
                                 input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.has = has; e.rd = rd; e.val = val;
        return e;
    endfunction

    // Retirement monitor: one scoreboard pop per edge on which the DUT was ready
    logic rdy_at_edge = 1'b0;
    always @(posedge clk_in) rdy_at_edge <= rdy_in;

    always @(negedge clk_in) begin
        if (!rst_in && rdy_at_edge) begin
            if (commit_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", 32'(commit_tag), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("commit_tag", 32'(commit_tag), 32'(e.tag));
                    chk("commit_wr_en", 32'(is_writing_rd), 32'(e.has));
                    chk("commit_rd", 32'(rd_reg_id), 32'(e.rd));
                    chk("commit_val", rd_val, e.val);
                end
            end else begin
                chk("idle_wr_en", 32'(is_writing_rd), 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_rd_id = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_val = '0; flush_pipline = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        cyc();
        sb.delete();
        rst_in = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) cyc();
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            alloc_valid = vecs[i].av; alloc_has_rd = vecs[i].has; alloc_rd_id = vecs[i].rd;
            wb_valid = vecs[i].wv; wb_tag = vecs[i].wt; wb_val = vecs[i].wval;
            #1;
            if (vecs[i].chk) begin
                chk($sformatf("v%0d_alloc_tag", i), 32'(alloc_tag), 32'(vecs[i].etag));
                chk($sformatf("v%0d_full", i), 32'(rob_full), 32'(vecs[i].efull));
                chk($sformatf("v%0d_empty", i), 32'(rob_empty), 32'(vecs[i].eempty));
                chk($sformatf("v%0d_cv", i), 32'(commit_valid), 32'(vecs[i].ecv));
            end
            if (vecs[i].av && !vecs[i].efull)
                sb.push_back(mke(vecs[i].etag, vecs[i].has, vecs[i].rd, vecs[i].sbval));
            cyc();
        end
        idle_inputs();
        vecs.delete();
    endtask

    initial begin
        idle_inputs();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        cyc();
        cyc();
        // Reset state
        chk("rst_wr_en", 32'(is_writing_rd), 32'd0);
        chk("rst_rd", 32'(rd_reg_id), 32'd0);
        chk("rst_val", rd_val, 32'd0);
        chk("rst_cv", 32'(commit_valid), 32'd0);
        chk("rst_ctag", 32'(commit_tag), 32'd0);
        chk("rst_empty", 32'(rob_empty), 32'd1);
        chk("rst_full", 32'(rob_full), 32'd0);
        chk("rst_atag", 32'(alloc_tag), 32'd0);
        rst_in = 1'b0;

        // Single alloc / wb / commit, two-cycle wb-to-write latency
        alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd_id = 5'd5;
        #1 chk("t1_atag", 32'(alloc_tag), 32'd0);
        sb.push_back(mke(3'd0, 1'b1, 5'd5, 32'h1234));
        cyc();
        idle_inputs();
        wb_valid = 1'b1; wb_tag = 3'd0; wb_val = 32'h1234;
        cyc();
        idle_inputs();
        chk("t1_not_yet", 32'(is_writing_rd), 32'd0);
        cyc();
        chk("t1_wr_en", 32'(is_writing_rd), 32'd1);
        chk("t1_rd", 32'(rd_reg_id), 32'd5);
        chk("t1_val", rd_val, 32'h1234);
        cyc();
        chk("t1_pulse_end", 32'(is_writing_rd), 32'd0);
        chk("t1_empty", 32'(rob_empty), 32'd1);

        // Out-of-order writeback, in-order retirement on consecutive cycles
        do_reset();
        vecs.push_back(mk(1,1,5'd1, 0,3'd0,32'h0, 32'hA, 1, 3'd0,0,1,0));
        vecs.push_back(mk(1,1,5'd2, 0,3'd0,32'h0, 32'hB, 1, 3'd1,0,0,0));
        vecs.push_back(mk(1,1,5'd3, 0,3'd0,32'h0, 32'hC, 1, 3'd2,0,0,0));
        vecs.push_back(mk(0,0,5'd0, 1,3'd2,32'hC, 32'h0, 1, 3'd3,0,0,0));
        vecs.push_back(mk(0,0,5'd0, 1,3'd1,32'hB, 32'h0, 1, 3'd3,0,0,0));
        vecs.push_back(mk(0,0,5'd0, 1,3'd0,32'hA, 32'h0, 1, 3'd3,0,0,0));
        vecs.push_back(mk(0,0,5'd0, 0,3'd0,32'h0, 32'h0, 1, 3'd3,0,0,0));
        vecs.push_back(mk(0,0,5'd0, 0,3'd0,32'h0, 32'h0, 1, 3'd3,0,0,1));
        vecs.push_back(mk(0,0,5'd0, 0,3'd0,32'h0, 32'h0, 1, 3'd3,0,0,1));
        vecs.push_back(mk(0,0,5'd0, 0,3'd0,32'h0, 32'h0, 1, 3'd3,0,1,1));
        vecs.push_back(mk(0,0,5'd0, 0,3'd0,32'h0, 32'h0, 1, 3'd3,0,1,0));
        run_table();
        wait_drain(10);

        // Fill, refuse when full, commit-while-full refusal, wrap to tag 0
        do_reset();
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1,1,5'(i+8), 0,3'd0,32'h0, 32'h100+32'(i), 1, 3'(i),0,(i==0),0));
        vecs.push_back(mk(1,1,5'd20, 0,3'd0,32'h0,   32'h999, 1, 3'd0,1,0,0));
        vecs.push_back(mk(1,1,5'd20, 0,3'd0,32'h0,   32'h999, 1, 3'd0,1,0,0));
        vecs.push_back(mk(1,1,5'd20, 1,3'd0,32'h100, 32'h999, 1, 3'd0,1,0,0));
        vecs.push_back(mk(1,1,5'd20, 0,3'd0,32'h0,   32'h999, 1, 3'd0,1,0,0));
        vecs.push_back(mk(1,1,5'd20, 0,3'd0,32'h0,   32'h999, 1, 3'd0,0,0,1));
        vecs.push_back(mk(0,0,5'd0,  1,3'd1,32'h101, 32'h0,   1, 3'd1,1,0,0));
        for (int i = 2; i < 8; i++)
            vecs.push_back(mk(0,0,5'd0, 1,3'(i),32'h100+32'(i), 32'h0, 0, 3'd0,0,0,0));
        vecs.push_back(mk(0,0,5'd0, 1,3'd0,32'h999, 32'h0, 0, 3'd0,0,0,0));
        run_table();
        wait_drain(30);

        // Flush with same-cycle wb and alloc
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd_id = 5'(i+1);
            cyc();
        end
        idle_inputs();
        wb_valid = 1'b1; wb_tag = 3'd1; wb_val = 32'h11;
        cyc();
        wb_tag = 3'd2; wb_val = 32'h22;
        cyc();
        chk("fl_pre_empty", 32'(rob_empty), 32'd0);
        flush_pipline = 1'b1;
        alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd_id = 5'd6;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_val = 32'hDEAD;
        cyc();
        idle_inputs();
        chk("fl_empty", 32'(rob_empty), 32'd1);
        chk("fl_atag", 32'(alloc_tag), 32'd0);
        chk("fl_wr_en", 32'(is_writing_rd), 32'd0);
        chk("fl_cv", 32'(commit_valid), 32'd0);
        cyc();
        chk("fl_wr_en2", 32'(is_writing_rd), 32'd0);
        chk("fl_cv2", 32'(commit_valid), 32'd0);
        alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd_id = 5'd7;
        #1 chk("fl_new_atag", 32'(alloc_tag), 32'd0);
        sb.push_back(mke(3'd0, 1'b1, 5'd7, 32'h77));
        cyc();
        idle_inputs();
        wb_valid = 1'b1; wb_tag = 3'd0; wb_val = 32'h77;
        cyc();
        idle_inputs();
        wait_drain(10);

        // Stall with a pulse outstanding and another head ready
        do_reset();
        alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd_id = 5'd9;
        sb.push_back(mke(3'd0, 1'b1, 5'd9, 32'h55));
        cyc();
        alloc_rd_id = 5'd10;
        sb.push_back(mke(3'd1, 1'b1, 5'd10, 32'h66));
        cyc();
        idle_inputs();
        wb_valid = 1'b1; wb_tag = 3'd0; wb_val = 32'h55;
        cyc();
        wb_tag = 3'd1; wb_val = 32'h66;
        cyc();
        rdy_in = 1'b0;
        alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd_id = 5'd13;
        wb_valid = 1'b1; wb_tag = 3'd1; wb_val = 32'hBAD;
        chk("st_first_rd", 32'(rd_reg_id), 32'd9);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("st%0d_wr_en", i), 32'(is_writing_rd), 32'd1);
            chk($sformatf("st%0d_rd", i), 32'(rd_reg_id), 32'd9);
            chk($sformatf("st%0d_val", i), rd_val, 32'h55);
            chk($sformatf("st%0d_ctag", i), 32'(commit_tag), 32'd0);
            chk($sformatf("st%0d_atag", i), 32'(alloc_tag), 32'd2);
        end
        idle_inputs();
        rdy_in = 1'b1;
        cyc();
        chk("st_resume_wr_en", 32'(is_writing_rd), 32'd1);
        chk("st_resume_rd", 32'(rd_reg_id), 32'd10);
        chk("st_resume_val", rd_val, 32'h66);
        chk("st_resume_ctag", 32'(commit_tag), 32'd1);
        chk("st_resume_empty", 32'(rob_empty), 32'd1);
        cyc();
        chk("st_pulse_end", 32'(is_writing_rd), 32'd0);
        chk("st_drained", 32'(sb.size()), 32'd0);

        // No-destination commit, then asynchronous reset mid-burst
        do_reset();
        alloc_valid = 1'b1; alloc_has_rd = 1'b0; alloc_rd_id = 5'd3;
        sb.push_back(mke(3'd0, 1'b0, 5'd3, 32'h77));
        cyc();
        alloc_has_rd = 1'b1; alloc_rd_id = 5'd11;
        sb.push_back(mke(3'd1, 1'b1, 5'd11, 32'h88));
        wb_valid = 1'b1; wb_tag = 3'd0; wb_val = 32'h77;
        cyc();
        alloc_rd_id = 5'd12;
        wb_tag = 3'd1; wb_val = 32'h88;
        cyc();
        idle_inputs();
        chk("nr_cv", 32'(commit_valid), 32'd1);
        chk("nr_wr_en", 32'(is_writing_rd), 32'd0);
        chk("nr_ctag", 32'(commit_tag), 32'd0);
        cyc();
        chk("burst_wr_en", 32'(is_writing_rd), 32'd1);
        chk("burst_rd", 32'(rd_reg_id), 32'd11);
        #2;
        rst_in = 1'b1;
        #1;
        chk("ar_wr_en", 32'(is_writing_rd), 32'd0);
        chk("ar_rd", 32'(rd_reg_id), 32'd0);
        chk("ar_val", rd_val, 32'd0);
        chk("ar_cv", 32'(commit_valid), 32'd0);
        chk("ar_ctag", 32'(commit_tag), 32'd0);
        chk("ar_empty", 32'(rob_empty), 32'd1);
        chk("ar_atag", 32'(alloc_tag), 32'd0);
        sb.delete();
        cyc();
        rst_in = 1'b0;
        cyc();
        chk("ar_after_cv", 32'(commit_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
